// File: rtl/xor_parity_frame.sv
// Frame accumulator: XORs up to FRAME_LEN words per frame, then holds the XOR,
// its parity, the word count and a short-frame flag until the consumer accepts.
module xor_parity_frame #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4,
   localparam int CW       = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             odd_mode,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CW-1:0]    out_count,
   output logic             out_short
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [CW-1:0] LEN_C = CW'(FRAME_LEN);

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_mode;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_xor;
   logic             r_out_parity;
   logic [CW-1:0]    r_out_count;
   logic             r_out_short;

   state_t           w_state_n;
   logic [WIDTH-1:0] w_acc_n;
   logic [CW-1:0]    w_cnt_n;
   logic             w_mode_n;
   logic [WIDTH-1:0] w_xor_n;
   logic             w_parity_n;
   logic [CW-1:0]    w_count_n;
   logic             w_short_n;
   logic             w_accept;
   logic [WIDTH-1:0] w_acc_a;
   logic [CW-1:0]    w_cnt_a;

   assign w_accept = in_valid & r_in_ready;
   // Accumulator and count as they stand after including this cycle's word, if any
   assign w_acc_a  = w_accept ? (r_acc ^ in_data) : r_acc;
   assign w_cnt_a  = w_accept ? (r_cnt + CW'(1)) : r_cnt;

   // Next-state, accumulator and result selection
   always_comb begin
      w_state_n  = r_state;
      w_acc_n    = r_acc;
      w_cnt_n    = r_cnt;
      w_mode_n   = r_mode;
      w_xor_n    = r_out_xor;
      w_parity_n = r_out_parity;
      w_count_n  = r_out_count;
      w_short_n  = r_out_short;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_acc_n  = in_data;
               w_cnt_n  = CW'(1);
               w_mode_n = odd_mode;
               if (FRAME_LEN == 1) begin
                  w_state_n  = S_HOLD;
                  w_xor_n    = in_data;
                  w_parity_n = (^in_data) ^ odd_mode;
                  w_count_n  = CW'(1);
                  w_short_n  = 1'b0;
               end else begin
                  w_state_n = S_ACCUM;
               end
            end else begin
               w_state_n = S_IDLE;
            end
         end
         S_ACCUM: begin
            w_acc_n = w_acc_a;
            w_cnt_n = w_cnt_a;
            // A flush that lands on the final word still counts as a full frame
            if (w_accept && (w_cnt_a == LEN_C)) begin
               w_state_n  = S_HOLD;
               w_xor_n    = w_acc_a;
               w_parity_n = (^w_acc_a) ^ r_mode;
               w_count_n  = w_cnt_a;
               w_short_n  = 1'b0;
            end else if (flush) begin
               w_state_n  = S_HOLD;
               w_xor_n    = w_acc_a;
               w_parity_n = (^w_acc_a) ^ r_mode;
               w_count_n  = w_cnt_a;
               w_short_n  = 1'b1;
            end else begin
               w_state_n = S_ACCUM;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               w_state_n  = S_IDLE;
               w_acc_n    = '0;
               w_cnt_n    = '0;
               w_mode_n   = 1'b0;
               w_xor_n    = '0;
               w_parity_n = 1'b0;
               w_count_n  = '0;
               w_short_n  = 1'b0;
            end else begin
               w_state_n = S_HOLD;
            end
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
   end

   // State, accumulator and registered output update
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_mode       <= 1'b0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_xor    <= '0;
         r_out_parity <= 1'b0;
         r_out_count  <= '0;
         r_out_short  <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_acc        <= w_acc_n;
         r_cnt        <= w_cnt_n;
         r_mode       <= w_mode_n;
         r_in_ready   <= (w_state_n != S_HOLD);
         r_out_valid  <= (w_state_n == S_HOLD);
         r_out_xor    <= w_xor_n;
         r_out_parity <= w_parity_n;
         r_out_count  <= w_count_n;
         r_out_short  <= w_short_n;
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign out_xor    = r_out_xor;
   assign out_parity = r_out_parity;
   assign out_count  = r_out_count;
   assign out_short  = r_out_short;

endmodule

// File: tb/tb_xor_parity_frame.sv
// Directed bench for xor_parity_frame (WIDTH=8, FRAME_LEN=4).
module tb_xor_parity_frame;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       odd_mode;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_xor;
   logic       out_parity;
   logic [2:0] out_count;
   logic       out_short;

   int n_cmp;
   int n_fail;

   xor_parity_frame #(.WIDTH(8), .FRAME_LEN(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .odd_mode(odd_mode), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_xor(out_xor), .out_parity(out_parity),
      .out_count(out_count), .out_short(out_short)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word for exactly one cycle (always accepted when in_ready=1)
   task automatic send(input logic [7:0] d, input logic m, input logic f);
      in_valid = 1'b1;
      in_data  = d;
      odd_mode = m;
      flush    = f;
      step();
      in_valid = 1'b0;
      in_data  = 8'h00;
      odd_mode = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic check_result(input string name, input logic [7:0] x, input logic p,
                               input logic [2:0] c, input logic s);
      n_cmp++;
      if ({out_valid, out_xor, out_parity, out_count, out_short} !== {1'b1, x, p, c, s}) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b xor=%02h par=%0b cnt=%0d short=%0b, want valid=1 xor=%02h par=%0b cnt=%0d short=%0b",
                  name, out_valid, out_xor, out_parity, out_count, out_short, x, p, c, s);
      end
   endtask

   task automatic check_released(input string name);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready, out_xor, out_parity, out_count, out_short} !== {1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL %s: got valid=%0b ready=%0b xor=%02h par=%0b cnt=%0d short=%0b, want 0 1 00 0 0 0",
                  name, out_valid, in_ready, out_xor, out_parity, out_count, out_short);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_cmp++;
      if ({out_valid, out_xor, out_parity, out_count, out_short} !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b xor=%02h par=%0b cnt=%0d short=%0b, want all 0",
                  out_valid, out_xor, out_parity, out_count, out_short);
      end
      rst = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %0b want 1", in_ready);
      end
   endtask

   task automatic test_full_frame();
      send(8'h01, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0);
      send(8'h04, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_early_valid: got %0b want 0", out_valid);
      end
      send(8'h08, 1'b0, 1'b0);
      check_result("full_frame", 8'h0F, 1'b0, 3'd4, 1'b0);
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL full_hold_ready: got %0b want 0", in_ready);
      end
      check_released("full_release");
   endtask

   task automatic test_odd_mode();
      send(8'h01, 1'b1, 1'b0);
      send(8'h02, 1'b0, 1'b0);
      send(8'h04, 1'b0, 1'b0);
      send(8'h08, 1'b0, 1'b0);
      check_result("odd_mode", 8'h0F, 1'b1, 3'd4, 1'b0);
      check_released("odd_release");
   endtask

   task automatic test_flush();
      send(8'hFF, 1'b0, 1'b0);
      send(8'h0F, 1'b0, 1'b1);
      check_result("flush_short", 8'hF0, 1'b0, 3'd2, 1'b1);
      check_released("flush_release");
      // Flush on the completing word: still a full frame
      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b0, 1'b0);
      send(8'h44, 1'b0, 1'b0);
      send(8'h80, 1'b0, 1'b1);
      check_result("flush_on_last", 8'hF7, 1'b0, 3'd4, 1'b0);
      check_released("flush_last_release");
   endtask

   task automatic test_back_to_back();
      send(8'h03, 1'b0, 1'b0);
      send(8'h05, 1'b0, 1'b0);
      send(8'h09, 1'b0, 1'b0);
      send(8'h10, 1'b0, 1'b0);
      check_result("bp_frame", 8'h1F, 1'b1, 3'd4, 1'b0);
      // Hold for 5 cycles with a word and a flush offered: neither may disturb HOLD
      in_valid = 1'b1;
      in_data  = 8'hA5;
      flush    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if ({out_valid, in_ready, out_xor, out_parity, out_count, out_short} !== {1'b1, 1'b0, 8'h1F, 1'b1, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got valid=%0b ready=%0b xor=%02h par=%0b cnt=%0d short=%0b",
                     i, out_valid, in_ready, out_xor, out_parity, out_count, out_short);
         end
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      check_released("bp_release");
      // Next frame offered in the very first IDLE cycle
      send(8'h10, 1'b0, 1'b0);
      send(8'h20, 1'b0, 1'b0);
      send(8'h40, 1'b0, 1'b0);
      send(8'h80, 1'b0, 1'b0);
      check_result("b2b_frame", 8'hF0, 1'b0, 3'd4, 1'b0);
      check_released("b2b_release");
   endtask

   task automatic test_reset_mid();
      send(8'hAA, 1'b1, 1'b0);
      send(8'h55, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL midrst_state: got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
      end
      send(8'h10, 1'b0, 1'b0);
      send(8'h20, 1'b0, 1'b0);
      send(8'h40, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_early_valid: got %0b want 0", out_valid);
      end
      send(8'h80, 1'b0, 1'b0);
      check_result("midrst_frame", 8'hF0, 1'b0, 3'd4, 1'b0);
      check_released("midrst_release");
   endtask

   task automatic test_gaps();
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL idle_flush: got valid=%0b ready=%0b want valid=0 ready=1", out_valid, in_ready);
      end
      send(8'h01, 1'b0, 1'b0);
      step();
      send(8'h02, 1'b0, 1'b0);
      step();
      send(8'h04, 1'b0, 1'b0);
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_early_valid: got %0b want 0", out_valid);
      end
      send(8'h08, 1'b0, 1'b0);
      check_result("gap_frame", 8'h0F, 1'b0, 3'd4, 1'b0);
      check_released("gap_release");
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      odd_mode  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_full_frame();
      test_odd_mode();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      test_gaps();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/xor_parity_frame.md
XOR_PARITY_FRAME -- requirements
Module: xor_parity_frame

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, which sets the data word width in bits (legal range 1..64).
REQ-002 SHALL provide parameter FRAME_LEN, default 4, which sets the number of words in a full frame (legal range 1..256).
REQ-003 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port in_data, input, WIDTH bits: the data word to accumulate.
REQ-009 SHALL have port odd_mode, input, 1 bit: parity sense, where 0 = even and 1 = odd.
REQ-010 SHALL have port flush, input, 1 bit: terminate the current frame early.
REQ-011 SHALL have port out_valid, output, 1 bit: a frame result is available.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_xor, output, WIDTH bits: the bitwise XOR of all words in the frame.
REQ-014 SHALL have port out_parity, output, 1 bit: the reduction XOR of out_xor, XORed with the stored odd_mode.
REQ-015 SHALL have port out_count, output, clog2(FRAME_LEN+1) bits: the number of words in the frame.
REQ-016 SHALL have port out_short, output, 1 bit: the frame was ended by flush before reaching FRAME_LEN words.

Function
REQ-017 SHALL implement three states: IDLE, ACCUM and HOLD.
REQ-018 SHALL define an accept as in_valid=1 and in_ready=1 in the same cycle.
REQ-019 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-020 SHALL, on an accept in IDLE: load acc=in_data, set cnt=1 and capture odd_mode into mode_q.
REQ-021 SHALL, after an IDLE accept, go to HOLD if FRAME_LEN=1, otherwise go to ACCUM.
REQ-022 SHALL, on an accept in ACCUM: set acc=acc^in_data and cnt=cnt+1.
REQ-023 SHALL, on an ACCUM accept that makes cnt reach FRAME_LEN, go to HOLD with out_short=0.
REQ-024 SHALL, on flush=1 in ACCUM, go to HOLD with out_short=1; if an accept occurs in the same cycle, that word is included first.
REQ-025 SHALL, when a flush cycle also completes FRAME_LEN words, report out_short=0.
REQ-026 SHALL ignore flush in IDLE and in HOLD.
REQ-027 SHALL ignore odd_mode everywhere except on the first accept of a frame.
REQ-028 SHALL assert out_valid=1 only in HOLD, starting the cycle after the final accept or flush (latency 1 clock).
REQ-029 SHALL register out_xor, out_parity, out_count and out_short, and hold them stable while out_valid=1 and out_ready=0.
REQ-030 SHALL, in HOLD with out_ready=1, return to IDLE next cycle and clear acc, cnt and all outputs to 0.
REQ-031 SHALL, when a word is offered in the first IDLE cycle after HOLD, accept it (no bubble beyond the HOLD exit cycle).
REQ-032 SHALL treat cycles with in_valid=0 in ACCUM as no-ops: acc and cnt unchanged, with no timeout.
REQ-033 SHALL size cnt so that it never wraps for any legal FRAME_LEN.

Reset
REQ-034 SHALL, with rst=1 at a clock edge, force state=IDLE, acc=0, cnt=0 and mode_q=0.
REQ-035 SHALL, with rst=1 at a clock edge, force out_valid=0, out_xor=0, out_parity=0, out_count=0 and out_short=0.
REQ-036 SHALL give rst priority over accept, flush and out_ready; a partial frame at reset is discarded with no output.
REQ-037 SHALL drive in_ready=1 in the first cycle after rst is released.

Verification (WIDTH=8, FRAME_LEN=4)
REQ-038 SHALL cover a full frame: odd_mode=0, words 0x01, 0x02, 0x04, 0x08 back-to-back -> out_valid one cycle after the 4th accept, with out_xor=0x0F, out_parity=0, out_count=4, out_short=0.
REQ-039 SHALL cover odd mode: the same words with odd_mode=1 on the first word only (0 afterwards) -> out_parity=1, out_xor=0x0F.
REQ-040 SHALL cover flush with data: 0xFF, then 0x0F with flush=1 in the same cycle -> out_xor=0xF0, out_count=2, out_short=1, out_parity=0.
REQ-041 SHALL cover backpressure: a completed frame with out_ready held at 0 for 5 cycles -> outputs constant and in_ready=0 throughout; out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-042 SHALL cover reset mid-frame: rst after 2 accepts, then 4 new words 0x10, 0x20, 0x40, 0x80 -> out_xor=0xF0, out_count=4, with no output from the aborted frame.
REQ-043 SHALL cover valid gaps and ignored flush: in_valid toggling 1, 0, 1, 0 over 4 words, and flush=1 while in IDLE -> result identical to the back-to-back case, with no spurious out_valid.
